// File: rtl/vga_sync_multi.sv
`default_nettype none
// ============================================================================
// vga_sync_multi : four-mode raster timing generator, mode switch at frame end
// Revision 1.0
// ============================================================================
module vga_sync_multi #(
  parameter int CW    = 12,
  parameter int DELAY = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    mode,
  output logic [1:0]    mode_active,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic [CW-1:0] hcnt,
  output logic [CW-1:0] vcnt,
  output logic          line_start,
  output logic          frame_start
);

  localparam int PW = 5 + 2 * CW;
  // Reset word carries mode-0 inactive sync levels so idle outputs look sane.
  localparam logic [PW-1:0] C_RST_WORD = {2'b11, 3'b000, {(2 * CW){1'b0}}};

  logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;
  logic [1:0]    mode_q, mode_d;
  logic [CW-1:0] w_hvis, w_hss, w_hse, w_htot;
  logic [CW-1:0] w_vvis, w_vss, w_vse, w_vtot;
  logic          w_pol, w_hend, w_vend, w_hsync_on, w_vsync_on;
  logic [PW-1:0] w_dec;
  logic [DELAY:0][PW-1:0] pipe_q;

  always_comb begin
    w_hvis = CW'(640);  w_hss = CW'(656);  w_hse = CW'(752);  w_htot = CW'(800);
    w_vvis = CW'(480);  w_vss = CW'(490);  w_vse = CW'(492);  w_vtot = CW'(525);
    w_pol  = 1'b0;
    case (mode_q)
      2'd1: begin
        w_hvis = CW'(800);  w_hss = CW'(840);  w_hse = CW'(968);  w_htot = CW'(1056);
        w_vvis = CW'(600);  w_vss = CW'(601);  w_vse = CW'(605);  w_vtot = CW'(628);
        w_pol  = 1'b1;
      end
      2'd2: begin
        w_hvis = CW'(1024); w_hss = CW'(1048); w_hse = CW'(1184); w_htot = CW'(1344);
        w_vvis = CW'(768);  w_vss = CW'(771);  w_vse = CW'(777);  w_vtot = CW'(806);
        w_pol  = 1'b0;
      end
      2'd3: begin
        w_hvis = CW'(1280); w_hss = CW'(1390); w_hse = CW'(1430); w_htot = CW'(1650);
        w_vvis = CW'(720);  w_vss = CW'(725);  w_vse = CW'(730);  w_vtot = CW'(750);
        w_pol  = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_hend = (hc_q == w_htot - 1'b1);
  assign w_vend = (vc_q == w_vtot - 1'b1);

  always_comb begin
    hc_d   = hc_q + 1'b1;
    vc_d   = vc_q;
    mode_d = mode_q;
    if (w_hend) begin
      hc_d = '0;
      if (w_vend) begin
        vc_d   = '0;
        mode_d = mode;
      end else begin
        vc_d = vc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hc_q   <= '0;
      vc_q   <= '0;
      mode_q <= 2'd0;
    end else begin
      hc_q   <= hc_d;
      vc_q   <= vc_d;
      mode_q <= mode_d;
    end
  end

  assign w_hsync_on = (hc_q >= w_hss) && (hc_q < w_hse);
  assign w_vsync_on = (vc_q >= w_vss) && (vc_q < w_vse);
  assign w_dec = {~(w_hsync_on ^ w_pol), ~(w_vsync_on ^ w_pol),
                  (hc_q < w_hvis) && (vc_q < w_vvis),
                  (hc_q == '0), (hc_q == '0) && (vc_q == '0),
                  hc_q, vc_q};

  if (DELAY == 0) begin : g_nodly
    always_ff @(posedge clk or posedge reset) begin
      if (reset) pipe_q <= C_RST_WORD;
      else       pipe_q <= w_dec;
    end
  end else begin : g_dly
    always_ff @(posedge clk or posedge reset) begin
      if (reset) pipe_q <= {(DELAY + 1){C_RST_WORD}};
      else       pipe_q <= {pipe_q[DELAY-1:0], w_dec};
    end
  end

  assign {hs, vs, de, line_start, frame_start, hcnt, vcnt} = pipe_q[DELAY];
  assign mode_active = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_multi.sv
`default_nettype none
// ============================================================================
// tb_vga_sync_multi : randomized-mode bench with table-driven raster model
// Revision 1.0
// ============================================================================
module tb_vga_sync_multi;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mode  = 2'd0;

  logic [1:0]  ma0, ma2;
  logic        hs0, vs0, de0, ls0, fs0, hs2, vs2, de2, ls2, fs2;
  logic [11:0] hcnt0, vcnt0, hcnt2, vcnt2;

  vga_sync_multi #(.CW(12), .DELAY(0)) dut0 (
    .clk(clk), .reset(reset), .mode(mode), .mode_active(ma0),
    .hs(hs0), .vs(vs0), .de(de0), .hcnt(hcnt0), .vcnt(vcnt0),
    .line_start(ls0), .frame_start(fs0)
  );

  vga_sync_multi #(.CW(12), .DELAY(2)) dut2 (
    .clk(clk), .reset(reset), .mode(mode), .mode_active(ma2),
    .hs(hs2), .vs(vs2), .de(de2), .hcnt(hcnt2), .vcnt(vcnt2),
    .line_start(ls2), .frame_start(fs2)
  );

  always #5 clk = ~clk;

  int HV [4] = '{640, 800, 1024, 1280};
  int HSS[4] = '{656, 840, 1048, 1390};
  int HSE[4] = '{752, 968, 1184, 1430};
  int HT [4] = '{800, 1056, 1344, 1650};
  int VV [4] = '{480, 600, 768, 720};
  int VSS[4] = '{490, 601, 771, 725};
  int VSE[4] = '{492, 605, 777, 730};
  int VT [4] = '{525, 628, 806, 750};
  bit POL[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  int  errors = 0;
  int  checks = 0;
  bit  chk_en = 1'b0;
  bit  rand_mode = 1'b0;
  logic [11:0] j_vc = 12'd0;

  // Reference raster: position and latched mode, plus the last three decoded samples.
  int m_hc = 0, m_vc = 0, m_mode = 0;
  int hist_hc[3], hist_vc[3], hist_md[3];
  bit hist_rst[3] = '{1'b1, 1'b1, 1'b1};

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hc = 0; m_vc = 0; m_mode = 0;
      for (int i = 0; i < 3; i++) hist_rst[i] = 1'b1;
    end else begin
      for (int i = 2; i > 0; i--) begin
        hist_hc[i] = hist_hc[i-1]; hist_vc[i] = hist_vc[i-1];
        hist_md[i] = hist_md[i-1]; hist_rst[i] = hist_rst[i-1];
      end
      hist_hc[0] = m_hc; hist_vc[0] = m_vc; hist_md[0] = m_mode; hist_rst[0] = 1'b0;
      if (m_hc == HT[m_mode] - 1) begin
        m_hc = 0;
        if (m_vc == VT[m_mode] - 1) begin
          m_vc = 0;
          m_mode = int'(mode);
        end else begin
          m_vc = m_vc + 1;
        end
      end else begin
        m_hc = m_hc + 1;
      end
    end
  end

  function automatic int dec(int h, int v, int m);
    bit hsa, vsa, hsl, vsl, den;
    hsa = (h >= HSS[m]) && (h < HSE[m]);
    vsa = (v >= VSS[m]) && (v < VSE[m]);
    hsl = POL[m] ? hsa : !hsa;
    vsl = POL[m] ? vsa : !vsa;
    den = (h < HV[m]) && (v < VV[m]);
    return int'({3'b000, hsl, vsl, den, h == 0, (h == 0) && (v == 0), 12'(h), 12'(v)});
  endfunction

  function automatic int exp_word(int k);
    if (hist_rst[k]) return int'({3'b000, 2'b11, 27'd0});
    return dec(hist_hc[k], hist_vc[k], hist_md[k]);
  endfunction

  task automatic check(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("dut0 outputs", int'({3'b000, hs0, vs0, de0, ls0, fs0, hcnt0, vcnt0}), exp_word(0));
      check("dut2 outputs", int'({3'b000, hs2, vs2, de2, ls2, fs2, hcnt2, vcnt2}), exp_word(2));
      check("dut0 mode_active", int'(ma0), m_mode);
      check("dut2 mode_active", int'(ma2), m_mode);
    end
  end

  task automatic step();
    @(negedge clk);
    if (rand_mode) mode = 2'($urandom_range(0, 3));
  endtask

  // Teleport the line counter of both instances; the model follows.
  task automatic jump(input int v);
    j_vc = 12'(v);
    force dut0.vc_q = j_vc;
    force dut2.vc_q = j_vc;
    #1;
    release dut0.vc_q;
    release dut2.vc_q;
    m_vc = v;
  endtask

  task automatic wait_for(input int sel, input int h, input int v, input string nm);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 10000) begin
      if (sel == 0) hit = (int'(hcnt0) == h) && (v < 0 || int'(vcnt0) == v);
      else          hit = (int'(hcnt2) == h) && (v < 0 || int'(vcnt2) == v);
      if (!hit) begin
        step();
        n++;
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL timeout %s: position h=%0d v=%0d never seen", nm, h, v);
    end
  endtask

  task automatic measure_line(input int sel, input string nm, input int expv);
    int n;
    wait_for(sel, 0, -1, nm);
    n = 0;
    do begin
      step();
      n++;
    end while (!(sel == 0 ? ls0 : ls2) && n < 5000);
    check(nm, n, expv);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_hs", int'(hs0), 1);
    check("rst_vs", int'(vs0), 1);
    check("rst_de", int'(de0), 0);
    check("rst_hcnt", int'(hcnt0), 0);
    check("rst_fs_d2", int'(fs2), 0);

    reset = 1'b0;
    rand_mode = 1'b1;
    step();
    check("first_fs", int'(fs0), 1);
    check("first_ls", int'(ls0), 1);
    check("first_de", int'(de0), 1);
    check("first_hcnt", int'(hcnt0), 0);
    check("first_fs_d2_early", int'(fs2), 0);
    step(); step();
    check("first_fs_d2", int'(fs2), 1);

    wait_for(0, 639, -1, "h639");
    check("de_at_639", int'(de0), 1);
    step();
    check("hcnt_640", int'(hcnt0), 640);
    check("de_at_640", int'(de0), 0);
    wait_for(0, 655, -1, "h655");
    check("hs_at_655", int'(hs0), 1);
    step();
    check("hs_at_656", int'(hs0), 0);
    wait_for(0, 751, -1, "h751");
    check("hs_at_751", int'(hs0), 0);
    step();
    check("hs_at_752", int'(hs0), 1);
    measure_line(0, "line_period_m0", 800);

    jump(488);
    wait_for(0, 799, 489, "v489");
    check("vs_at_489", int'(vs0), 1);
    step();
    check("vs_at_490", int'(vs0), 0);
    wait_for(0, 799, 491, "v491");
    check("vs_at_491", int'(vs0), 0);
    step();
    check("vs_at_492", int'(vs0), 1);

    rand_mode = 1'b0;
    mode = 2'd1;
    jump(100);
    wait_for(0, 0, 101, "v101");
    check("mode_held_midframe", int'(ma0), 0);
    jump(523);
    wait_for(0, 0, 0, "frame_m1");
    check("mode1_adopted", int'(ma0), 1);
    check("mode1_fs", int'(fs0), 1);
    check("mode1_idle_hs", int'(hs0), 0);
    check("mode1_idle_vs", int'(vs0), 0);
    measure_line(0, "line_period_m1", 1056);
    wait_for(0, 839, -1, "h839");
    check("m1_hs_at_839", int'(hs0), 0);
    step();
    check("m1_hs_at_840", int'(hs0), 1);
    wait_for(0, 967, -1, "h967");
    check("m1_hs_at_967", int'(hs0), 1);
    step();
    check("m1_hs_at_968", int'(hs0), 0);

    mode = 2'd3;
    jump(626);
    wait_for(0, 0, 0, "frame_m3");
    check("mode3_adopted", int'(ma0), 3);
    check("mode3_adopted_d2", int'(ma2), 3);
    wait_for(0, 1390, -1, "h1390");
    check("m3_hs_d0", int'(hs0), 1);
    check("m3_hcnt_d2_lag", int'(hcnt2), 1388);
    check("m3_hs_d2_lag", int'(hs2), 0);
    step();
    check("m3_hs_d2_1389", int'(hs2), 0);
    step();
    check("m3_hcnt_d2_1390", int'(hcnt2), 1390);
    check("m3_hs_d2_1390", int'(hs2), 1);
    measure_line(1, "line_period_m3_d2", 1650);
    jump(748);
    wait_for(1, 1649, 749, "v749_d2");
    check("m3_vs_d2_749", int'(vs2), 0);
    step();
    check("m3_wrap_vcnt_d2", int'(vcnt2), 0);
    check("m3_wrap_fs_d2", int'(fs2), 1);
    check("m3_wrap_hcnt_d0", int'(hcnt0), 2);

    mode = 2'd2;
    jump(748);
    wait_for(0, 0, 0, "frame_m2");
    check("mode2_adopted", int'(ma0), 2);
    jump(300);
    rand_mode = 1'b1;
    wait_for(0, 500, 300, "h500v300");
    check("m2_de_before_rst", int'(de0), 1);
    #2 reset = 1'b1;
    #1;
    check("arst_hs", int'(hs0), 1);
    check("arst_vs", int'(vs0), 1);
    check("arst_de", int'(de0), 0);
    check("arst_hcnt", int'(hcnt0), 0);
    check("arst_vcnt", int'(vcnt0), 0);
    check("arst_mode", int'(ma0), 0);
    check("arst_de_d2", int'(de2), 0);
    check("arst_hcnt_d2", int'(hcnt2), 0);
    step(); step();
    reset = 1'b0;
    step();
    check("restart_fs", int'(fs0), 1);
    check("restart_mode", int'(ma0), 0);
    check("restart_de", int'(de0), 1);
    repeat (2000) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
